// File: rtl/reg_write_arbiter_if.sv
// Bundle between the writeback stage / multi-cycle unit and the register-file
// write arbiter. The arbiter sits on the slave modport.
interface reg_write_arbiter_if #(
    parameter int PTR_W = 2
);
    logic          PIPE_WE;
    logic [3:0]    PIPE_A;
    logic [31:0]   PIPE_WD;
    logic          MC_VALID;
    logic [3:0]    MC_A;
    logic [31:0]   MC_WD;
    logic          MC_READY;
    logic          WE3;
    logic [3:0]    A3;
    logic [31:0]   WD3;
    logic [14:0]   PENDING;
    logic [PTR_W:0] COUNT;
    logic          R15_DROP;
    logic          ORDER_ERR;

    modport master (
        output PIPE_WE, PIPE_A, PIPE_WD, MC_VALID, MC_A, MC_WD,
        input  MC_READY, WE3, A3, WD3, PENDING, COUNT, R15_DROP, ORDER_ERR
    );

    modport slave (
        input  PIPE_WE, PIPE_A, PIPE_WD, MC_VALID, MC_A, MC_WD,
        output MC_READY, WE3, A3, WD3, PENDING, COUNT, R15_DROP, ORDER_ERR
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, and
// multi-cycle results wait in a FIFO that drains on cycles the pipeline is idle.
module reg_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic           CLK,
    input logic           RESET,
    reg_write_arbiter_if.slave bus
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0]     R15  = 4'd15;

    logic [3:0]       mem_a [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             accept, push, pop, mc_drop, pipe_drop, pipe_write;
    logic [14:0]      pend;

    // MC handshake: a result transfers on a posedge where MC_VALID && MC_READY;
    // the producer holds MC_A/MC_WD stable until then. MC_READY depends only on
    // occupancy, so a pop on the same edge never frees a slot early.
    assign bus.MC_READY = (count != FULL);
    assign accept       = bus.MC_VALID && bus.MC_READY;
    assign push         = accept && (bus.MC_A != R15);
    assign mc_drop      = accept && (bus.MC_A == R15);
    assign pipe_drop    = bus.PIPE_WE && (bus.PIPE_A == R15);
    assign pipe_write   = bus.PIPE_WE && (bus.PIPE_A != R15);
    assign pop          = !bus.PIPE_WE && (count != '0);

    assign bus.COUNT   = count;
    assign bus.PENDING = pend;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count && mem_a[i] != R15)
                pend[mem_a[i]] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.MC_A;
            mem_d[wr_ptr] <= bus.MC_WD;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.WE3       <= 1'b0;
            bus.A3        <= '0;
            bus.WD3       <= '0;
            bus.R15_DROP  <= 1'b0;
            bus.ORDER_ERR <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase

            bus.R15_DROP <= pipe_drop || mc_drop;
            if (pipe_write && pend[bus.PIPE_A])
                bus.ORDER_ERR <= 1'b1;

            if (pipe_write) begin
                bus.WE3 <= 1'b1;
                bus.A3  <= bus.PIPE_A;
                bus.WD3 <= bus.PIPE_WD;
            end else if (pop) begin
                bus.WE3 <= 1'b1;
                bus.A3  <= mem_a[rd_ptr];
                bus.WD3 <= mem_d[rd_ptr];
            end else begin
                bus.WE3 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_reg_write_arbiter;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    reg_write_arbiter_if #(.PTR_W(PTR_W)) bus();

    reg_write_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: queued {addr, data} entries plus expected registered outputs.
    logic [35:0] exp_q[$];
    logic        m_we;
    logic [3:0]  m_a;
    logic [31:0] m_wd;
    logic        m_drop;
    logic        m_oerr;

    function automatic logic [14:0] model_pending();
        logic [14:0] p;
        p = '0;
        foreach (exp_q[i]) p[exp_q[i][35:32]] = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge RESET) begin : model
        logic        ready;
        logic        mc_take;
        logic [14:0] pend;
        logic [35:0] e;
        if (RESET) begin
            exp_q.delete();
            m_we = 1'b0; m_a = '0; m_wd = '0; m_drop = 1'b0; m_oerr = 1'b0;
        end else begin
            ready   = exp_q.size() < DEPTH;
            pend    = model_pending();
            mc_take = bus.MC_VALID && ready;
            if (bus.PIPE_WE && bus.PIPE_A != 4'd15 && pend[bus.PIPE_A]) m_oerr = 1'b1;
            m_drop = (bus.PIPE_WE && bus.PIPE_A == 4'd15) || (mc_take && bus.MC_A == 4'd15);
            if (bus.PIPE_WE) begin
                if (bus.PIPE_A != 4'd15) begin
                    m_we = 1'b1; m_a = bus.PIPE_A; m_wd = bus.PIPE_WD;
                end else begin
                    m_we = 1'b0;
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_we = 1'b1; m_a = e[35:32]; m_wd = e[31:0];
            end else begin
                m_we = 1'b0;
            end
            if (mc_take && bus.MC_A != 4'd15) exp_q.push_back({bus.MC_A, bus.MC_WD});
        end
    end

    always begin
        @(posedge CLK);
        #1;
        if (cmp_en && !RESET) begin
            chk("we3", 32'(bus.WE3), 32'(m_we));
            chk("a3", 32'(bus.A3), 32'(m_a));
            chk("wd3", bus.WD3, m_wd);
            chk("count", 32'(bus.COUNT), 32'(exp_q.size()));
            chk("pending", 32'(bus.PENDING), 32'(model_pending()));
            chk("mc_ready", 32'(bus.MC_READY), 32'(exp_q.size() < DEPTH));
            chk("r15_drop", 32'(bus.R15_DROP), 32'(m_drop));
            chk("order_err", 32'(bus.ORDER_ERR), 32'(m_oerr));
        end
    end

    task automatic drive(input logic pwe, input logic [3:0] pa, input logic [31:0] pwd,
                         input logic mv, input logic [3:0] ma, input logic [31:0] mwd);
        bus.PIPE_WE = pwe; bus.PIPE_A = pa; bus.PIPE_WD = pwd;
        bus.MC_VALID = mv; bus.MC_A = ma; bus.MC_WD = mwd;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RESET = 1'b1;
        repeat (2) step();
        chk("rst_we3", 32'(bus.WE3), 32'd0);
        chk("rst_count", 32'(bus.COUNT), 32'd0);
        chk("rst_pending", 32'(bus.PENDING), 32'd0);
        chk("rst_mc_ready", 32'(bus.MC_READY), 32'd1);
        RESET = 1'b0;
        cmp_en = 1'b1;
        step();

        // Pipe write alone
        drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        step();
        chk("pipe_we3", 32'(bus.WE3), 32'd1);
        chk("pipe_a3", 32'(bus.A3), 32'd5);
        chk("pipe_wd3", bus.WD3, 32'hDEADBEEF);
        idle();
        step();
        chk("pipe_we3_after", 32'(bus.WE3), 32'd0);

        // MC queued behind a busy pipeline
        drive(1'b1, 4'd1, 32'hAAAA, 1'b1, 4'd3, 32'h11);
        step();
        drive(1'b1, 4'd1, 32'hBBBB, 1'b1, 4'd7, 32'h22);
        step();
        chk("mcq_count_e2", 32'(bus.COUNT), 32'd2);
        chk("mcq_pending_e2", 32'(bus.PENDING), 32'h0088);
        drive(1'b1, 4'd1, 32'hCCCC, 1'b0, 4'd0, 32'd0);
        step();
        step();
        chk("mcq_pending_e4", 32'(bus.PENDING), 32'h0088);
        chk("mcq_count_e4", 32'(bus.COUNT), 32'd2);
        idle();
        step();
        chk("mcq_drain1_a3", 32'(bus.A3), 32'd3);
        chk("mcq_drain1_wd3", bus.WD3, 32'h11);
        chk("mcq_pending_e5", 32'(bus.PENDING), 32'h0080);
        step();
        chk("mcq_drain2_a3", 32'(bus.A3), 32'd7);
        chk("mcq_drain2_wd3", bus.WD3, 32'h22);
        chk("mcq_pending_e6", 32'(bus.PENDING), 32'h0000);
        step();
        chk("mcq_we3_idle", 32'(bus.WE3), 32'd0);

        // Full FIFO
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd2, 32'h5000 + 32'(i), 1'b1, 4'(8 + i), 32'h100 + 32'(i));
            step();
        end
        chk("full_count", 32'(bus.COUNT), 32'd4);
        chk("full_ready", 32'(bus.MC_READY), 32'd0);
        drive(1'b1, 4'd2, 32'h5004, 1'b1, 4'd12, 32'h104);
        step();
        chk("full_no_accept", 32'(bus.COUNT), 32'd4);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("full_drain_a3", 32'(bus.A3), 32'(8 + i));
            chk("full_drain_wd3", bus.WD3, 32'h100 + 32'(i));
            if (i == 0) chk("full_ready_after_pop", 32'(bus.MC_READY), 32'd1);
        end
        step();

        // R15 drops
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'hF00D);
        step();
        chk("mc15_drop", 32'(bus.R15_DROP), 32'd1);
        chk("mc15_count", 32'(bus.COUNT), 32'd0);
        idle();
        step();
        chk("mc15_drop_end", 32'(bus.R15_DROP), 32'd0);
        drive(1'b1, 4'd15, 32'h1234, 1'b0, 4'd0, 32'd0);
        step();
        chk("pipe15_we3", 32'(bus.WE3), 32'd0);
        chk("pipe15_drop", 32'(bus.R15_DROP), 32'd1);
        idle();
        step();
        chk("pipe15_drop_end", 32'(bus.R15_DROP), 32'd0);

        // Ordering error and duplicate destinations
        chk("oerr_clear", 32'(bus.ORDER_ERR), 32'd0);
        drive(1'b1, 4'd1, 32'h1, 1'b1, 4'd4, 32'h44);
        step();
        drive(1'b1, 4'd4, 32'h99, 1'b0, 4'd0, 32'd0);
        step();
        chk("oerr_set", 32'(bus.ORDER_ERR), 32'd1);
        idle();
        step();
        chk("oerr_sticky", 32'(bus.ORDER_ERR), 32'd1);
        chk("oerr_pop_wd3", bus.WD3, 32'h44);
        drive(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h21);
        step();
        drive(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h22);
        step();
        chk("dup_pending", 32'(bus.PENDING), 32'h0004);
        idle();
        step();
        chk("dup_pending_one_left", 32'(bus.PENDING), 32'h0004);
        step();
        chk("dup_pending_clear", 32'(bus.PENDING), 32'h0000);
        chk("dup_last_wd3", bus.WD3, 32'h22);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd1, 32'h7, 1'b1, 4'(5 + i), 32'h70 + 32'(i));
            step();
        end
        chk("mid_count_before", 32'(bus.COUNT), 32'd3);
        RESET = 1'b1;
        #1;
        chk("mid_rst_count", 32'(bus.COUNT), 32'd0);
        chk("mid_rst_pending", 32'(bus.PENDING), 32'd0);
        chk("mid_rst_ready", 32'(bus.MC_READY), 32'd1);
        chk("mid_rst_we3", 32'(bus.WE3), 32'd0);
        chk("mid_rst_oerr", 32'(bus.ORDER_ERR), 32'd0);
        #1;
        RESET = 1'b0;
        idle();
        step();
        chk("post_rst_we3", 32'(bus.WE3), 32'd0);
        chk("post_rst_count", 32'(bus.COUNT), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 299) begin
                RESET = 1'b1;
                #2;
                RESET = 1'b0;
            end
            drive(1'($urandom_range(0, 99) < 45), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 99) < 55), 4'($urandom_range(0, 15)), $urandom);
            step();
        end
        idle();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Drives the register file's single write port (WE3/A3/WD3) from two producers:
  - the pipeline writeback stage, which has highest priority and never stalls;
  - the multi-cycle unit (multiply/divide), whose results are queued in a small FIFO and drained only on cycles the pipeline does not write.
- Exports a pending-destination mask so the hazard unit can stall reads of registers with queued results.
- Sits between the writeback stage / multi-cycle unit and the register file.

Parameters:
- DEPTH, 4, multi-cycle result FIFO entries (power of two, ≥2).
- PTR_W, 2, log2(DEPTH).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- PIPE_WE  input  1  pipeline writeback request this cycle.
- PIPE_A  input  4  pipeline destination register.
- PIPE_WD  input  32  pipeline write data.
- MC_VALID  input  1  multi-cycle result offered.
- MC_A  input  4  multi-cycle destination register.
- MC_WD  input  32  multi-cycle result data.
- MC_READY  output  1  FIFO can accept; equals (COUNT < DEPTH), combinational.
- WE3  output  1  register-file write enable, registered.
- A3  output  4  register-file write address, registered.
- WD3  output  32  register-file write data, registered.
- PENDING  output  15  bit r set iff a valid FIFO entry targets register r (r = 0..14); combinational from FIFO state.
- COUNT  output  PTR_W+1  FIFO occupancy.
- R15_DROP  output  1  one-cycle pulse: a write to register 15 was discarded.
- ORDER_ERR  output  1  sticky: pipeline wrote a register that was pending in the FIFO.

Behaviour:
- RESET (asynchronous, active-high):
  - WE3=0, A3=0, WD3=0, R15_DROP=0, ORDER_ERR=0.
  - FIFO read/write pointers=0, COUNT=0, therefore PENDING=0 and MC_READY=1.
  - Reset asserted mid-operation discards all queued entries; no write is issued after reset deasserts until a new request arrives.
- Accept: MC handshake completes at a posedge when MC_VALID && MC_READY.
  - MC_A!=15: push {MC_A, MC_WD}.
  - MC_A==15: discard (no push) and pulse R15_DROP next cycle.
- Output selection at each posedge (mutually exclusive; values appear on WE3/A3/WD3 in the following cycle):
  - PIPE_WE && PIPE_A!=15: WE3<=1, A3<=PIPE_A, WD3<=PIPE_WD. The FIFO does not drain.
  - PIPE_WE && PIPE_A==15: WE3<=0, R15_DROP<=1. The FIFO does not drain that cycle either.
  - !PIPE_WE && COUNT>0: pop head; WE3<=1, A3/WD3<=head entry.
  - Otherwise: WE3<=0. A3/WD3 hold their previous values.
- R15_DROP is 1 for exactly one cycle per dropped write. A same-edge pipe drop and MC drop produce a single pulse.
- Latency:
  - Pipe request at edge N → WE3 high during cycle N..N+1; the register file commits on the following negedge.
  - MC entry accepted at edge N into an empty FIFO drains at the earliest at edge N+1. There is no bypass around the FIFO.
- Simultaneous push and pop in one cycle: COUNT unchanged. When full, MC_READY=0 even if a pop occurs that edge.
- Pointers wrap modulo DEPTH. FIFO order is strictly preserved.
- Multiple FIFO entries may target the same register. The PENDING bit stays set until the last such entry pops.
- ORDER_ERR is set at any posedge where PIPE_WE && PIPE_A!=15 && PENDING[PIPE_A]. It clears only on RESET.
- WE3 is never 1 with A3==15.

Test Plan:
- Reset → WE3=0, COUNT=0, PENDING=0, MC_READY=1. Assert RESET mid-cycle with COUNT=3 → all state cleared immediately, with no clock edge needed.
- Pipe write alone: PIPE_WE=1, PIPE_A=5, PIPE_WD=0xDEADBEEF at edge N → WE3=1, A3=5, WD3=0xDEADBEEF during cycle N..N+1; WE3=0 after it.
- MC queued behind pipe:
  - MC writes R3=0x11 and R7=0x22 at edges 1–2 while PIPE_WE=1 for edges 1–4 → PENDING=0x0088 and COUNT=2 through edge 4.
  - Drains R3 at edge 5 and R7 at edge 6 → PENDING=0 afterwards.
- Full FIFO: push 4 entries with PIPE_WE held high → MC_READY=0 and a 5th MC_VALID is not accepted. Drop PIPE_WE → 4 drains in order, and MC_READY=1 after the first pop.
- R15 drop: MC_A=15 accepted → no push, R15_DROP pulse 1 cycle. PIPE_A=15 → WE3=0, R15_DROP pulse.
- Ordering: queue R4, then PIPE_WE to R4 → ORDER_ERR=1 and it stays high. Duplicate entries R2, R2 → PENDING[2] clears only after the second pop.
